// File: rtl/hdmi_read_scheduler.sv
// rtl/hdmi_read_scheduler.sv - burst read request sequencer for the HDMI pixel FIFO
// Optional accepted-burst counter o_req_count under HDMI_READ_SCHED_STATS_EN.
module hdmi_read_scheduler #(
  parameter int ADDR_W      = 32,
  parameter int CHUNK_WORDS = 64,
  parameter int CHUNK_BYTES = 256,
  parameter int PREFETCH    = 2,
  parameter int MAX_PEND    = 7,
  parameter int FIFO_DEPTH  = 512
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_frame_base,
  input  logic [15:0]       i_line_stride,
  input  logic [7:0]        i_chunks_per_line,
  input  logic              i_read_go,
  input  logic              i_read_next_line,
  input  logic              i_read_next_chunk,
  input  logic              i_read_done,
  input  logic [9:0]        i_fifo_words,
  output logic              o_req_valid,
  output logic [ADDR_W-1:0] o_req_addr,
  input  logic              i_req_ready,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_pend_err
`ifdef HDMI_READ_SCHED_STATS_EN
  ,
  output logic [15:0]       o_req_count
`endif
);

  localparam int FIFO_LIMIT = FIFO_DEPTH - CHUNK_WORDS;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_t;

  state_t            r_state;
  logic              r_req_valid;
  logic [ADDR_W-1:0] r_req_addr;
  logic              r_busy;
  logic              r_frame_done;
  logic              r_pend_err;
  logic [2:0]        r_pend;
  logic [7:0]        r_chunk_idx;
  logic              r_line_adv;
  logic [ADDR_W-1:0] r_line_addr;
  logic [ADDR_W-1:0] r_chunk_addr;
  logic [15:0]       r_stride;
  logic [7:0]        r_cpl;

  logic              w_accept;
  logic              w_stop;
  logic              w_adv;
  logic              w_fifo_ok;
  logic              w_can_issue;
  logic              w_pend_ovf;
  logic [2:0]        w_pend_next;
  logic [ADDR_W-1:0] w_next_line;

  assign w_accept    = r_req_valid & i_req_ready;
  assign w_stop      = i_read_done | ~i_start;
  // A line advance applies now if nothing is held, or when the held request is accepted.
  assign w_adv       = (i_read_next_line & (~r_req_valid | w_accept)) | (r_line_adv & w_accept);
  assign w_fifo_ok   = ({1'b0, i_fifo_words} <= 11'(FIFO_LIMIT));
  assign w_can_issue = ~r_req_valid & (r_pend != 3'd0) & (r_chunk_idx < r_cpl) & w_fifo_ok
                     & ~r_line_adv & ~i_read_next_line;
  assign w_pend_ovf  = i_read_next_chunk & ~w_accept & (r_pend == 3'(MAX_PEND));
  assign w_next_line = r_line_addr + ADDR_W'(r_stride);

  always_comb begin
    w_pend_next = r_pend;
    if (w_accept && !i_read_next_chunk) begin
      w_pend_next = (r_pend == 3'd0) ? 3'd0 : r_pend - 3'd1;
    end else if (!w_accept && i_read_next_chunk && r_pend != 3'(MAX_PEND)) begin
      w_pend_next = r_pend + 3'd1;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_req_valid  <= 1'b0;
      r_req_addr   <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_pend_err   <= 1'b0;
      r_pend       <= '0;
      r_chunk_idx  <= '0;
      r_line_adv   <= 1'b0;
      r_line_addr  <= '0;
      r_chunk_addr <= '0;
      r_stride     <= '0;
      r_cpl        <= '0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_read_go && i_start) begin
            r_stride     <= i_line_stride;
            r_cpl        <= i_chunks_per_line;
            r_line_addr  <= i_frame_base;
            r_chunk_addr <= i_frame_base;
            r_chunk_idx  <= '0;
            r_pend       <= 3'(PREFETCH);
            r_pend_err   <= 1'b0;
            r_line_adv   <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          r_pend <= w_pend_next;
          if (w_pend_ovf) r_pend_err <= 1'b1;
          if (w_accept) begin
            r_req_valid  <= 1'b0;
            r_chunk_addr <= r_chunk_addr + ADDR_W'(CHUNK_BYTES);
            r_chunk_idx  <= r_chunk_idx + 8'd1;
          end
          // Stop wins over a same-cycle line advance, which is simply dropped.
          if (w_stop) begin
            r_line_adv <= 1'b0;
            r_state    <= S_DRAIN;
          end else if (w_adv) begin
            r_line_addr  <= w_next_line;
            r_chunk_addr <= w_next_line;
            r_chunk_idx  <= '0;
            r_pend       <= 3'(PREFETCH);
            r_line_adv   <= 1'b0;
          end else begin
            if (i_read_next_line && r_req_valid) r_line_adv <= 1'b1;
            if (w_can_issue) begin
              r_req_valid <= 1'b1;
              r_req_addr  <= r_chunk_addr;
            end
          end
        end
        S_DRAIN: begin
          if (!r_req_valid || i_req_ready) begin
            r_req_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef HDMI_READ_SCHED_STATS_EN
  logic [15:0] r_req_count;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_req_count <= '0;
    end else if (r_state == S_IDLE) begin
      if (i_read_go && i_start) r_req_count <= '0;
    end else if (w_accept && r_req_count != 16'hFFFF) begin
      r_req_count <= r_req_count + 16'd1;
    end
  end

  assign o_req_count = r_req_count;
`endif

  assign o_req_valid  = r_req_valid;
  assign o_req_addr   = r_req_addr;
  assign o_busy       = r_busy;
  assign o_frame_done = r_frame_done;
  assign o_pend_err   = r_pend_err;

endmodule

// File: tb/tb_hdmi_read_scheduler.sv
// tb/tb_hdmi_read_scheduler.sv - self-checking bench for hdmi_read_scheduler
module tb_hdmi_read_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start = 1'b0;
  logic [31:0] fb = '0;
  logic [15:0] stride = '0;
  logic [7:0]  cpl = '0;
  logic        go = 1'b0, rnl = 1'b0, rnc = 1'b0, done = 1'b0;
  logic [9:0]  fifo = '0;
  logic        rdy = 1'b0;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        busy, fdone, perr;
`ifdef HDMI_READ_SCHED_STATS_EN
  logic [15:0] req_count;
`endif

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state: line base plus chunk index gives the chunk address.
  int          m_state;  // 0 idle, 1 active, 2 drain
  int          m_idx, m_pend, m_cpl, m_cnt;
  bit          m_valid, m_adv, m_err, m_done;
  logic [31:0] m_addr, m_base;
  logic [15:0] m_stride;

  logic [31:0] acc_q[$];
  logic [31:0] last_acc;

  always #5 clk = ~clk;

  hdmi_read_scheduler dut (
    .i_clock           (clk),
    .i_reset           (rst),
    .i_start           (start),
    .i_frame_base      (fb),
    .i_line_stride     (stride),
    .i_chunks_per_line (cpl),
    .i_read_go         (go),
    .i_read_next_line  (rnl),
    .i_read_next_chunk (rnc),
    .i_read_done       (done),
    .i_fifo_words      (fifo),
    .o_req_valid       (req_valid),
    .o_req_addr        (req_addr),
    .i_req_ready       (rdy),
    .o_busy            (busy),
    .o_frame_done      (fdone),
    .o_pend_err        (perr)
`ifdef HDMI_READ_SCHED_STATS_EN
    ,
    .o_req_count       (req_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_idx = 0; m_pend = 0; m_cpl = 0; m_cnt = 0;
    m_valid = 0; m_adv = 0; m_err = 0; m_done = 0;
    m_addr = '0; m_base = '0; m_stride = '0;
  endtask

  // Applies one clock of the scheduling rules to the model, using the inputs now driven.
  task automatic model_step();
    bit acc, was_valid, issue;
    logic [31:0] cur;
    acc = m_valid && rdy;
    was_valid = m_valid;
    cur = m_base + 32'(m_idx) * 32'd256;
    m_done = 0;
    if (m_state == 0) begin
      if (go && start) begin
        m_base = fb; m_stride = stride; m_cpl = int'(cpl);
        m_idx = 0; m_pend = 2; m_err = 0; m_adv = 0; m_cnt = 0; m_state = 1;
      end
    end else if (m_state == 1) begin
      issue = !was_valid && m_pend > 0 && m_idx < m_cpl && fifo <= 10'd448 && !m_adv && !rnl;
      if (acc) begin
        m_valid = 0; m_idx++;
        if (m_cnt < 65535) m_cnt++;
      end
      if (rnc && !acc && m_pend == 7) m_err = 1;
      if (acc && !rnc) m_pend = (m_pend > 0) ? m_pend - 1 : 0;
      else if (rnc && !acc && m_pend < 7) m_pend++;
      if (done || !start) begin
        m_state = 2; m_adv = 0;
      end else if ((rnl && (!was_valid || acc)) || (m_adv && acc)) begin
        m_base = m_base + {16'd0, m_stride}; m_idx = 0; m_pend = 2; m_adv = 0;
      end else begin
        if (rnl && was_valid) m_adv = 1;
        if (issue) begin m_valid = 1; m_addr = cur; end
      end
    end else begin
      if (!was_valid || rdy) begin
        if (acc && m_cnt < 65535) m_cnt++;
        m_valid = 0; m_state = 0; m_done = 1;
      end
    end
  endtask

  task automatic cycle();
    if (req_valid && rdy) begin
      acc_q.push_back(req_addr);
      last_acc = req_addr;
    end
    model_step();
    @(posedge clk); #1;
    check("req_valid", {31'd0, req_valid}, {31'd0, m_valid});
    if (m_valid) check("req_addr", req_addr, m_addr);
    check("busy", {31'd0, busy}, {31'd0, m_state != 0});
    check("frame_done", {31'd0, fdone}, {31'd0, m_done});
    check("pend_err", {31'd0, perr}, {31'd0, m_err});
`ifdef HDMI_READ_SCHED_STATS_EN
    check("req_count", {16'd0, req_count}, 32'(m_cnt));
`endif
    @(negedge clk);
    go = 0; rnl = 0; rnc = 0; done = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    @(posedge clk); #2;
    check("rst_valid", {31'd0, req_valid}, 32'd0);
    check("rst_addr", req_addr, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_fdone", {31'd0, fdone}, 32'd0);
    check("rst_perr", {31'd0, perr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Frame start: exactly two prefetch requests
    fb = 32'h1000_0000; stride = 16'd3200; cpl = 8'd13; rdy = 1; fifo = 0; start = 1;
    acc_q.delete(); go = 1; run(12);
    check("fs_count", 32'(acc_q.size()), 32'd2);
    check("fs_addr0", acc_q[0], 32'h1000_0000);
    check("fs_addr1", acc_q[1], 32'h1000_0100);

    // Chunk pulses fill out line 0, then overrun without issuing
    acc_q.delete();
    for (int k = 0; k < 13; k++) begin rnc = 1; run(4); end
    check("l0_count", 32'(acc_q.size()), 32'd11);
    check("l0_last", last_acc, 32'h1000_0C00);
    acc_q.delete(); rnl = 1; run(8);
    check("l1_count", 32'(acc_q.size()), 32'd2);
    check("l1_addr0", acc_q[0], 32'h1000_0C80);
    check("l1_addr1", acc_q[1], 32'h1000_0D80);

    // Backpressure with a line advance while the request is held
    rdy = 0; rnc = 1; run(3);
    check("bp_held", {31'd0, req_valid}, 32'd1);
    for (int k = 0; k < 20; k++) begin
      if (k == 5) rnl = 1;
      run(1);
      check("bp_stable", req_addr, 32'h1000_0E80);
    end
    rdy = 1; acc_q.delete(); run(8);
    check("bp_count", 32'(acc_q.size()), 32'd3);
    check("bp_addr0", acc_q[0], 32'h1000_0E80);
    check("bp_addr1", acc_q[1], 32'h1000_1900);
    check("bp_addr2", acc_q[2], 32'h1000_1A00);

    // FIFO throttle at the 448-word threshold
    fifo = 10'd449; rnc = 1; run(6);
    check("thr_block", {31'd0, req_valid}, 32'd0);
    fifo = 10'd448; run(1);
    check("thr_rise", {31'd0, req_valid}, 32'd1);
    check("thr_addr", req_addr, 32'h1000_1B00);
    fifo = 0; run(3);

    // Pending overflow under backpressure
    rdy = 0;
    for (int k = 0; k < 7; k++) begin rnc = 1; run(1); end
    check("ovf_pre", {31'd0, perr}, 32'd0);
    rnc = 1; run(1);
    check("ovf_err", {31'd0, perr}, 32'd1);

    // Abort while a request is held
    start = 0; run(5);
    check("abort_held", {31'd0, req_valid}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd1);
    rdy = 1; run(1);
    check("abort_fdone", {31'd0, fdone}, 32'd1);
    check("abort_idle", {31'd0, busy}, 32'd0);
    start = 1; run(2);

    // New frame clears pend_err; zero chunks per line issues nothing
    fb = 32'h2000_0000; cpl = 8'd0; go = 1; run(1);
    check("go_clr_err", {31'd0, perr}, 32'd0);
    acc_q.delete();
    for (int k = 0; k < 4; k++) begin rnc = 1; run(2); end
    rnl = 1; run(3);
    check("cpl0_count", 32'(acc_q.size()), 32'd0);
    done = 1; run(3);

    // Simultaneous line advance and done
    cpl = 8'd13; go = 1; run(8);
    rnl = 1; done = 1; run(4);

    // Randomised frames
    for (int f = 0; f < 6; f++) begin
      fb = $urandom; stride = 16'($urandom); cpl = 8'($urandom_range(0, 20));
      start = 1; go = 1; run(1);
      for (int c = 0; c < 400; c++) begin
        rnc  = ($urandom_range(0, 5) == 0);
        rnl  = ($urandom_range(0, 39) == 0);
        go   = ($urandom_range(0, 99) == 0);
        rdy  = ($urandom_range(0, 9) < 7);
        fifo = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(449, 1023))
                                           : 10'($urandom_range(0, 448));
        run(1);
      end
      if (f % 2 == 1) start = 0;
      else begin done = 1; rnl = ($urandom_range(0, 1) == 1); end
      run(1);
      start = 1; rdy = 1; run(4);
    end

    // Async reset while a request is held
    fb = 32'h3000_0000; cpl = 8'd5; fifo = 0; rdy = 0; go = 1; run(3);
    check("ar_pre", {31'd0, req_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", {31'd0, req_valid}, 32'd0);
    check("ar_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hdmi_read_scheduler.md
Name: hdmi_read_scheduler

Overview:
- Sequences frame-buffer reads for the HDMI output core.
- Consumes the core's read_go / read_next_line / read_next_chunk / read_done pulses and turns them into burst read requests (address plus valid/ready) for the bus-master read engine that fills the pixel FIFO.
- Generates addresses, primes the FIFO at line start, throttles on FIFO space, and queues chunk requests that arrive while the bus is busy.

Parameters:
- ADDR_W, 32, request address width.
- CHUNK_WORDS, 64, 32-bit words per burst; matches the core's 64-pixel chunk period.
- CHUNK_BYTES, 256, address increment per burst (CHUNK_WORDS*4).
- PREFETCH, 2, chunks queued automatically at frame/line start.
- MAX_PEND, 7, pending-chunk counter saturation value (3-bit counter).
- FIFO_DEPTH, 512, pixel FIFO depth in words.

Ports:
- clock, in, 1, sole clock.
- reset, in, 1, asynchronous active-high reset.
- start, in, 1, enable; low forces an abort to IDLE.
- frame_base, in, ADDR_W, frame start byte address; sampled on read_go.
- line_stride, in, 16, bytes between line starts; sampled on read_go.
- chunks_per_line, in, 8, bursts per line (10/13/20 for 640/800/1280); sampled on read_go.
- read_go, read_next_line, read_next_chunk, read_done, in, 1 each, single-cycle pulses from the HDMI core.
- fifo_words, in, 10, current pixel FIFO fill level.
- req_valid, out, 1, burst request valid.
- req_addr, out, ADDR_W, burst byte address; stable while req_valid=1.
- req_ready, in, 1, read engine accepts the request.
- busy, out, 1, high in any state other than IDLE.
- frame_done, out, 1, one-cycle pulse on DRAIN to IDLE.
- pend_err, out, 1, sticky flag: chunk pulse arrived with pend=MAX_PEND; cleared on read_go.

Behaviour:
- Reset (async): state=IDLE; req_valid=0, req_addr=0, busy=0, frame_done=0, pend_err=0, pend=0, chunk_idx=0, line_adv=0.
- States: IDLE, ACTIVE, DRAIN.
- IDLE:
  - On read_go with start=1: latch frame_base/line_stride/chunks_per_line.
  - Set line_addr=chunk_addr=frame_base, chunk_idx=0, pend=PREFETCH, clear pend_err.
  - Go to ACTIVE. All other pulses are ignored.
- ACTIVE issue rule: raise req_valid with req_addr=chunk_addr when all of the following hold:
  - pend>0
  - chunk_idx<chunks_per_line
  - fifo_words <= FIFO_DEPTH-CHUNK_WORDS
  - line_adv=0
  - req_valid is registered, so it rises the cycle after the condition holds.
- Handshake:
  - Once raised, req_valid and req_addr hold until the cycle with req_ready=1, regardless of any other input.
  - On accept: chunk_addr+=CHUNK_BYTES, chunk_idx++, pend-- (saturating at 0), req_valid=0 for at least one cycle.
- read_next_chunk: pend++ (saturating at MAX_PEND; at saturation set pend_err). If an accept happens in the same cycle, pend is unchanged.
- read_next_line:
  - If req_valid=0: line_addr+=line_stride, chunk_addr=new line_addr, chunk_idx=0, pend=PREFETCH.
  - If req_valid=1 and not accepted that cycle: set line_adv=1. The advance is applied in the accept cycle and overrides that accept's chunk_addr/chunk_idx/pend updates.
- Address arithmetic: modulo 2^ADDR_W, with no wrap detection.
- Chunk overrun: read_next_chunk after chunk_idx reaches chunks_per_line still increments pend, but no request is issued until the next line advance.
- read_done in ACTIVE: go to DRAIN.
  - DRAIN issues nothing new and waits for any held request to be accepted.
  - Then IDLE, with frame_done=1 for one cycle.
- start=0 in ACTIVE: same as read_done (DRAIN, then IDLE), and frame_done still pulses.
- read_go outside IDLE: ignored.
- Simultaneous read_next_line and read_done: read_done wins and the line advance is dropped.
- chunks_per_line=0: ACTIVE issues nothing and exits normally on read_done.

Optional Feature:
- Macro: HDMI_READ_SCHED_STATS_EN.
- Defined: adds output req_count (16 bits), counting accepted bursts. It is cleared on read_go, saturates at 0xFFFF, and holds its value in IDLE.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Frame start: frame_base=0x1000_0000, stride=3200, cpl=13, req_ready=1, fifo_words=0; pulse read_go -> exactly two requests, at 0x1000_0000 and 0x1000_0100, then req_valid stays 0.
- Line advance: after 13 chunk pulses plus read_next_line -> next requests at 0x1000_0C80 and 0x1000_0D80. No request beyond address 0x1000_0C00 on line 0.
- Backpressure: req_ready=0 for 20 cycles with read_next_line in cycle 5 -> req_addr stable for all 20 cycles; the first request after accept is the new line base.
- Throttle: fifo_words=449 -> no req_valid. Dropping to 448 -> req_valid rises one cycle later.
- Overflow: req_ready=0 with 8 chunk pulses -> pend=7 and pend_err=1; read_go in the next frame clears pend_err.
- Abort and reset: start=0 while a request is held -> request held until req_ready, then frame_done pulse and IDLE. Async reset mid-request -> req_valid=0 immediately, without waiting for a clock edge.
